cruce_sequencer: RTL and testbench

Phase sequencer for a two-street intersection (street A, street B). It owns the light timing, latches pedestrian button presses and vehicle demand, and decides when each street gets green and when each pedestrian crossing gets its walk window. It drives the same light and walk signals the intersection consumes: semA, semB, A_peatonal and B_peatonal. It replaces the fixed-cycle rotation with demand-driven scheduling.

---
 rtl/cruce_sequencer_pkg.sv | 17 +
 rtl/cruce_sequencer_phase_timer.sv | 28 ++
 rtl/cruce_sequencer.sv | 143 ++++++++++++++
 tb/tb_cruce_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cruce_sequencer_pkg.sv
// Shared light encodings and phase codes for the intersection sequencer.
package cruce_sequencer_pkg;

  localparam logic [1:0] ROJO     = 2'b00;
  localparam logic [1:0] AMARILLO = 2'b01;
  localparam logic [1:0] VERDE    = 2'b10;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    A_CLEAR  = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    B_CLEAR  = 3'd5
  } state_t;

endpackage

// File: rtl/cruce_sequencer_phase_timer.sv
// Loadable down-counter that measures how long the sequencer has been in a phase.
module phase_timer #(
  parameter int               CNT_W     = 4,
  parameter logic [CNT_W-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             expired
);

  // Load wins over counting; counting stops at zero so a resting phase holds there.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RST_VALUE;
    end else if (load) begin
      value <= load_value;
    end else if (enb && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/cruce_sequencer.sv
// Demand-driven phase sequencer for a two-street intersection with pedestrian walk windows.
//
// state    | meaning
// ---------+-----------------------------------------------
// A_GREEN  | A green, B red; B crossing may walk
// A_YELLOW | A yellow, B red
// A_CLEAR  | all red clearance after A
// B_GREEN  | B green, A red; A crossing may walk
// B_YELLOW | B yellow, A red
// B_CLEAR  | all red clearance after B (reset state)
module cruce_sequencer
  import cruce_sequencer_pkg::*;
#(
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       btnA,
  input  logic       btnB,
  input  logic       carA,
  input  logic       carB,
  output logic [1:0] semA,
  output logic [1:0] semB,
  output logic       A_peatonal,
  output logic       B_peatonal,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  // elapsed < T_WALK  <=>  timer >= T_GREEN - T_WALK
  localparam logic [CNT_W-1:0] WALK_MIN  = CNT_W'(T_GREEN - T_WALK);

  state_t           state, state_nxt;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic [CNT_W-1:0] timer;
  logic             expired;
  logic             reqA, reqB;
  logic             walkA, walkB;
  logic             enter_a_green, enter_b_green;

  phase_timer #(
    .CNT_W     (CNT_W),
    .RST_VALUE (LD_ALLRED)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .load       (load),
    .load_value (load_value),
    .value      (timer),
    .expired    (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= B_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and timer reload; greens only yield when someone is waiting.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_value = LD_ALLRED;
    if (enb && expired) begin
      case (state)
        A_GREEN:  if (carB || reqA || reqB) state_nxt = A_YELLOW;
        A_YELLOW: state_nxt = A_CLEAR;
        A_CLEAR:  state_nxt = B_GREEN;
        B_GREEN:  if (carA || reqA || reqB) state_nxt = B_YELLOW;
        B_YELLOW: state_nxt = B_CLEAR;
        B_CLEAR:  state_nxt = A_GREEN;
        default:  state_nxt = B_CLEAR;
      endcase
    end
    if (state_nxt != state) begin
      load = 1'b1;
      case (state_nxt)
        A_GREEN, B_GREEN:   load_value = LD_GREEN;
        A_YELLOW, B_YELLOW: load_value = LD_YELLOW;
        default:            load_value = LD_ALLRED;
      endcase
    end
  end

  assign enter_a_green = (state_nxt == A_GREEN) && (state != A_GREEN);
  assign enter_b_green = (state_nxt == B_GREEN) && (state != B_GREEN);

  // Request latches; a pending request becomes the walk grant when its street turns red.
  always_ff @(posedge clk) begin
    if (rst) begin
      reqA  <= 1'b0;
      reqB  <= 1'b0;
      walkA <= 1'b0;
      walkB <= 1'b0;
    end else begin
      if (enter_b_green) begin
        walkA <= reqA;
        reqA  <= 1'b0;
      end else if (btnA) begin
        reqA  <= 1'b1;
      end
      if (enter_a_green) begin
        walkB <= reqB;
        reqB  <= 1'b0;
      end else if (btnB) begin
        reqB  <= 1'b1;
      end
    end
  end

  // Light decode straight from the state register.
  always_comb begin
    semA = ROJO;
    semB = ROJO;
    case (state)
      A_GREEN:  semA = VERDE;
      A_YELLOW: semA = AMARILLO;
      B_GREEN:  semB = VERDE;
      B_YELLOW: semB = AMARILLO;
      default: begin
        semA = ROJO;
        semB = ROJO;
      end
    endcase
  end

  assign A_peatonal = walkA && (state == B_GREEN) && (timer >= WALK_MIN);
  assign B_peatonal = walkB && (state == A_GREEN) && (timer >= WALK_MIN);
  assign phase      = state;

endmodule

// File: tb/tb_cruce_sequencer.sv
// Directed bench for the intersection sequencer with hand-computed phase timings.
module tb_cruce_sequencer;

  logic       clk = 1'b0;
  logic       rst, enb, btnA, btnB, carA, carB;
  logic [1:0] semA, semB;
  logic       A_peatonal, B_peatonal;
  logic [2:0] phase;

  int tests  = 0;
  int errors = 0;

  localparam int PA_GREEN  = 0;
  localparam int PA_YELLOW = 1;
  localparam int PA_CLEAR  = 2;
  localparam int PB_GREEN  = 3;
  localparam int PB_YELLOW = 4;
  localparam int PB_CLEAR  = 5;

  cruce_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .btnA       (btnA),
    .btnB       (btnB),
    .carA       (carA),
    .carB       (carB),
    .semA       (semA),
    .semB       (semB),
    .A_peatonal (A_peatonal),
    .B_peatonal (B_peatonal),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic safety();
    logic ok;
    ok = !((semA != 2'b00) && (semB != 2'b00)) &&
         !(A_peatonal && (semA != 2'b00)) &&
         !(B_peatonal && (semB != 2'b00)) &&
         (semA != 2'b11) && (semB != 2'b11);
    check("safety", int'(ok), 1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      safety();
    end
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0;
    btnA = 1'b0; btnB = 1'b0; carA = 1'b0; carB = 1'b0;

    // reset and start
    tick(2);
    check("rst_semA", int'(semA), 0);
    check("rst_semB", int'(semB), 0);
    check("rst_walkA", int'(A_peatonal), 0);
    check("rst_walkB", int'(B_peatonal), 0);
    check("rst_phase", int'(phase), PB_CLEAR);
    rst = 1'b0; enb = 1'b1;
    tick(1);
    check("start_semA", int'(semA), 2);
    check("start_semB", int'(semB), 0);
    check("start_walkB", int'(B_peatonal), 0);

    // no demand: A rests in green
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_semA", int'(semA), 2);
      check("idle_semB", int'(semB), 0);
    end

    // vehicle on B: resting green yields immediately
    carB = 1'b1;
    tick(1);
    check("carB_yel", int'(semA), 1);
    tick(1);
    check("yel_c2", int'(semA), 1);
    tick(1);
    check("clear_phase", int'(phase), PA_CLEAR);
    check("clear_semB", int'(semB), 0);
    tick(1);
    check("b_green", int'(semB), 2);
    tick(30);
    check("b_rest", int'(semB), 2);
    check("b_rest_phase", int'(phase), PB_GREEN);
    carA = 1'b1;
    tick(1);
    check("carA_yel", int'(semB), 1);
    tick(1);
    check("byel_c2", int'(semB), 1);
    tick(1);
    check("bclear", int'(phase), PB_CLEAR);
    tick(1);
    // A green lasts exactly 8 cycles under demand
    for (int i = 0; i < 8; i++) begin
      check("a_green_len", int'(phase), PA_GREEN);
      tick(1);
    end
    check("a_green_end", int'(phase), PA_YELLOW);
    // full rotation is 22 cycles
    tick(21);
    check("rot_21", int'(phase), PA_GREEN);
    tick(1);
    check("rot_22", int'(phase), PA_YELLOW);

    // reach a fresh A green without demand
    carA = 1'b0; carB = 1'b0;
    tick(3);
    check("b_green2", int'(phase), PB_GREEN);
    check("no_walkA", int'(A_peatonal), 0);
    tick(10);
    check("b_rest2", int'(phase), PB_GREEN);
    carA = 1'b1;
    tick(1);
    carA = 1'b0;
    check("b_yel2", int'(phase), PB_YELLOW);
    tick(3);
    check("a_green3", int'(phase), PA_GREEN);

    // btnA pulse during A green cycle 3
    tick(2);
    btnA = 1'b1;
    tick(1);
    btnA = 1'b0;
    tick(4);
    check("btnA_c8", int'(phase), PA_GREEN);
    tick(1);
    check("btnA_yel", int'(phase), PA_YELLOW);
    tick(2);
    check("btnA_clear", int'(phase), PA_CLEAR);
    btnA = 1'b1;  // press on the B green entry edge is consumed
    tick(1);
    btnA = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("walkA_on", int'(A_peatonal), 1);
      tick(1);
    end
    check("walkA_off", int'(A_peatonal), 0);
    tick(7);
    check("consumed_rest", int'(phase), PB_GREEN);
    check("rest_walk_off", int'(A_peatonal), 0);
    carA = 1'b1;
    tick(1);
    carA = 1'b0;
    tick(3);
    check("a_green4", int'(phase), PA_GREEN);
    tick(7);
    carB = 1'b1;
    tick(1);
    carB = 1'b0;
    tick(3);
    check("b_green4", int'(phase), PB_GREEN);
    check("b_green4_nowalk", int'(A_peatonal), 0);
    tick(1);
    btnA = 1'b1;  // press during B green cycle 2
    tick(1);
    btnA = 1'b0;
    check("late_press_nowalk", int'(A_peatonal), 0);
    tick(5);
    check("late_c8", int'(phase), PB_GREEN);
    tick(1);
    check("late_yel", int'(phase), PB_YELLOW);
    tick(3);
    check("a_green5", int'(phase), PA_GREEN);
    check("a_green5_nowalkB", int'(B_peatonal), 0);
    tick(8);
    check("a_yel5", int'(phase), PA_YELLOW);
    tick(3);
    check("served_walk", int'(A_peatonal), 1);
    tick(1);
    check("served_walk_c2", int'(A_peatonal), 1);

    // reset during an active walk, buttons held on the same edge
    rst = 1'b1; btnA = 1'b1; btnB = 1'b1;
    tick(1);
    check("mid_rst_semA", int'(semA), 0);
    check("mid_rst_semB", int'(semB), 0);
    check("mid_rst_walkA", int'(A_peatonal), 0);
    check("mid_rst_phase", int'(phase), PB_CLEAR);
    rst = 1'b0; btnA = 1'b0; btnB = 1'b0;
    tick(1);
    check("post_rst_A", int'(phase), PA_GREEN);
    check("post_rst_walkB", int'(B_peatonal), 0);
    tick(10);
    check("post_rst_rest", int'(phase), PA_GREEN);

    // freeze during A yellow
    carB = 1'b1;
    tick(1);
    carB = 1'b0;
    check("frz_yel", int'(semA), 1);
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("frz_hold", int'(semA), 1);
    end
    enb = 1'b1;
    tick(1);
    check("frz_yel_c2", int'(semA), 1);
    tick(1);
    check("frz_clear", int'(phase), PA_CLEAR);
    tick(1);
    check("frz_b_green", int'(phase), PB_GREEN);

    // btnB served at the next A green
    btnB = 1'b1;
    tick(1);
    btnB = 1'b0;
    tick(6);
    check("btnB_c8", int'(phase), PB_GREEN);
    tick(1);
    check("btnB_yel", int'(phase), PB_YELLOW);
    tick(3);
    check("walkB_c1", int'(B_peatonal), 1);
    tick(3);
    check("walkB_c4", int'(B_peatonal), 1);
    tick(1);
    check("walkB_c5", int'(B_peatonal), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
